// File: rtl/clk_rst_seq.sv
// Staged reset sequencer fed by the MMCM locked status: releases system logic, then the scan engine.
// Optional macro CLK_RST_LOSS_CNT_EN enables the saturating lock-loss event counter.
module clk_rst_seq #(
    parameter int SYNC_STAGES     = 2,
    parameter int LOCK_STABLE_CYC = 1024,
    parameter int STAGE_GAP_CYC   = 16,
    parameter int LOSS_FILTER_CYC = 4,
    parameter int CNT_W           = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             locked,
    output logic             rst_sys,
    output logic             rst_scan,
    output logic             sys_ready,
    output logic             lock_lost,
    output logic [CNT_W-1:0] lock_loss_cnt
);

    localparam int STAB_W = (LOCK_STABLE_CYC > 1) ? $clog2(LOCK_STABLE_CYC) : 1;
    localparam int GAP_W  = (STAGE_GAP_CYC > 1)   ? $clog2(STAGE_GAP_CYC)   : 1;
    localparam int FLT_W  = (LOSS_FILTER_CYC > 1) ? $clog2(LOSS_FILTER_CYC) : 1;

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        STABLE    = 2'd1,
        REL_SYS   = 2'd2,
        RUN       = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [STAB_W-1:0]      stab_cnt_q, stab_cnt_d;
    logic [GAP_W-1:0]       gap_cnt_q, gap_cnt_d;
    logic [FLT_W-1:0]       flt_cnt_q, flt_cnt_d;
    logic                   loss_evt_q, loss_evt_d;
    logic                   rst_sys_q, rst_sys_d;
    logic                   rst_scan_q, rst_scan_d;
    logic                   sys_ready_q, sys_ready_d;
    logic                   lock_lost_q, lock_lost_d;
    logic                   locked_s;
    logic                   released_s;
    logic                   loss_s;

    assign locked_s   = sync_q[SYNC_STAGES-1];
    assign released_s = (state_q == REL_SYS) || (state_q == RUN);
    assign sync_d     = {sync_q[SYNC_STAGES-2:0], locked};

    // Filtered loss: this edge would be the LOSS_FILTER_CYC-th consecutive unlocked sample.
    assign loss_s = released_s && !locked_s && (flt_cnt_q == FLT_W'(LOSS_FILTER_CYC - 1));

    // Next-state and counter logic; a filtered loss overrides gap completion.
    always_comb begin
        state_d    = state_q;
        stab_cnt_d = stab_cnt_q;
        gap_cnt_d  = gap_cnt_q;
        loss_evt_d = 1'b0;
        if (released_s && !locked_s && !loss_s) begin
            flt_cnt_d = flt_cnt_q + FLT_W'(1);
        end else begin
            flt_cnt_d = {FLT_W{1'b0}};
        end
        case (state_q)
            WAIT_LOCK: begin
                stab_cnt_d = {STAB_W{1'b0}};
                gap_cnt_d  = {GAP_W{1'b0}};
                if (locked_s) begin
                    state_d = STABLE;
                end else begin
                    state_d = WAIT_LOCK;
                end
            end
            STABLE: begin
                if (!locked_s) begin
                    state_d    = WAIT_LOCK;
                    stab_cnt_d = {STAB_W{1'b0}};
                end else if (stab_cnt_q == STAB_W'(LOCK_STABLE_CYC - 1)) begin
                    state_d   = REL_SYS;
                    gap_cnt_d = {GAP_W{1'b0}};
                end else begin
                    stab_cnt_d = stab_cnt_q + STAB_W'(1);
                end
            end
            REL_SYS: begin
                if (loss_s) begin
                    state_d    = WAIT_LOCK;
                    loss_evt_d = 1'b1;
                end else if (gap_cnt_q == GAP_W'(STAGE_GAP_CYC - 1)) begin
                    state_d = RUN;
                end else begin
                    gap_cnt_d = gap_cnt_q + GAP_W'(1);
                end
            end
            RUN: begin
                if (loss_s) begin
                    state_d    = WAIT_LOCK;
                    loss_evt_d = 1'b1;
                end else begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d = WAIT_LOCK;
            end
        endcase
    end

    // Output decode from the current state, registered on the next edge.
    always_comb begin
        rst_sys_d   = !released_s;
        rst_scan_d  = (state_q != RUN);
        sys_ready_d = (state_q == RUN);
        lock_lost_d = loss_evt_q;
    end

    // State, synchroniser, counters and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= WAIT_LOCK;
            sync_q      <= {SYNC_STAGES{1'b0}};
            stab_cnt_q  <= {STAB_W{1'b0}};
            gap_cnt_q   <= {GAP_W{1'b0}};
            flt_cnt_q   <= {FLT_W{1'b0}};
            loss_evt_q  <= 1'b0;
            rst_sys_q   <= 1'b1;
            rst_scan_q  <= 1'b1;
            sys_ready_q <= 1'b0;
            lock_lost_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sync_q      <= sync_d;
            stab_cnt_q  <= stab_cnt_d;
            gap_cnt_q   <= gap_cnt_d;
            flt_cnt_q   <= flt_cnt_d;
            loss_evt_q  <= loss_evt_d;
            rst_sys_q   <= rst_sys_d;
            rst_scan_q  <= rst_scan_d;
            sys_ready_q <= sys_ready_d;
            lock_lost_q <= lock_lost_d;
        end
    end

    assign rst_sys   = rst_sys_q;
    assign rst_scan  = rst_scan_q;
    assign sys_ready = sys_ready_q;
    assign lock_lost = lock_lost_q;

`ifdef CLK_RST_LOSS_CNT_EN
    logic [CNT_W-1:0] loss_cnt_q, loss_cnt_d;

    // Saturating count, advanced in step with the lock_lost pulse.
    always_comb begin
        if (loss_evt_q && (loss_cnt_q != {CNT_W{1'b1}})) begin
            loss_cnt_d = loss_cnt_q + CNT_W'(1);
        end else begin
            loss_cnt_d = loss_cnt_q;
        end
    end

    // Lock-loss counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            loss_cnt_q <= {CNT_W{1'b0}};
        end else begin
            loss_cnt_q <= loss_cnt_d;
        end
    end

    assign lock_loss_cnt = loss_cnt_q;
`else
    assign lock_loss_cnt = {CNT_W{1'b0}};
`endif

endmodule
